// File: rtl/tocador_nota.sv
// Note player: alternates NOTE/PAUSE phases while conta is held, pulsing muda_nota
// at each phase end and driving a square wave at the latched note's pitch during NOTE.
module tocador_nota #(
    parameter int T_NOTA  = 25_000_000,
    parameter int T_PAUSA = 5_000_000,
    parameter int T_W     = 25,
    parameter int ESCALA  = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       zera,
    input  logic       conta,
    input  logic       som,
    input  logic [3:0] nota,
    output logic       buzzer,
    output logic       muda_nota,
    output logic       ocupado,
    output logic [3:0] nota_atual,
    output logic [1:0] db_estado
);

    typedef enum logic [1:0] {
        OCIOSO = 2'b00,
        NOTA   = 2'b01,
        PAUSA  = 2'b10
    } estado_t;

    localparam logic [T_W-1:0] T_NOTA_FIM  = T_W'(T_NOTA - 1);
    localparam logic [T_W-1:0] T_PAUSA_FIM = T_W'(T_PAUSA - 1);

    // Scaled tone half-period for a note code, never below one cycle.
    function automatic logic [16:0] meio_periodo(input logic [3:0] codigo);
        logic [16:0] h;
        case (codigo)
            4'd1:    h = 17'd95420;
            4'd2:    h = 17'd85034;
            4'd3:    h = 17'd75758;
            4'd4:    h = 17'd71633;
            4'd5:    h = 17'd63776;
            4'd6:    h = 17'd56818;
            4'd7:    h = 17'd50607;
            default: h = 17'd1;
        endcase
        h = h >> ESCALA;
        if (h == 17'd0) begin
            h = 17'd1;
        end else begin
            h = h;
        end
        return h;
    endfunction

    function automatic logic nota_valida(input logic [3:0] codigo);
        return (codigo >= 4'd1) && (codigo <= 4'd7);
    endfunction

    estado_t        estado_q, estado_d;
    logic [T_W-1:0] t_q, t_d;
    logic [16:0]    div_q, div_d;
    logic           tom_q, tom_d;
    logic [3:0]     nota_q, nota_d;
    logic           muda_q, muda_d;
    logic           buzzer_q, buzzer_d;
    logic [16:0]    div_fim_s;

    assign div_fim_s = meio_periodo(nota_q) - 17'd1;

    // Next-state, phase timing and tone divider; zera overrides everything.
    always_comb begin
        estado_d = estado_q;
        t_d      = t_q;
        div_d    = div_q;
        tom_d    = tom_q;
        nota_d   = nota_q;
        muda_d   = 1'b0;
        if (zera) begin
            estado_d = OCIOSO;
            t_d      = '0;
            div_d    = 17'd0;
            tom_d    = 1'b0;
            nota_d   = 4'd0;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    if (conta) begin
                        estado_d = NOTA;
                        nota_d   = nota;
                        t_d      = '0;
                        div_d    = 17'd0;
                        tom_d    = 1'b0;
                    end else begin
                        estado_d = OCIOSO;
                    end
                end
                NOTA: begin
                    if (!conta) begin
                        estado_d = NOTA;
                    end else if (t_q == T_NOTA_FIM) begin
                        estado_d = PAUSA;
                        t_d      = '0;
                        div_d    = 17'd0;
                        tom_d    = 1'b0;
                        muda_d   = 1'b1;
                    end else begin
                        t_d = t_q + T_W'(1);
                        if (div_q == div_fim_s) begin
                            div_d = 17'd0;
                            tom_d = ~tom_q;
                        end else begin
                            div_d = div_q + 17'd1;
                        end
                    end
                end
                PAUSA: begin
                    if (!conta) begin
                        estado_d = PAUSA;
                    end else if (t_q == T_PAUSA_FIM) begin
                        estado_d = NOTA;
                        nota_d   = nota;
                        t_d      = '0;
                        div_d    = 17'd0;
                        tom_d    = 1'b0;
                        muda_d   = 1'b1;
                    end else begin
                        t_d = t_q + T_W'(1);
                    end
                end
                default: begin
                    estado_d = OCIOSO;
                    t_d      = '0;
                    div_d    = 17'd0;
                    tom_d    = 1'b0;
                    nota_d   = 4'd0;
                end
            endcase
        end
        buzzer_d = tom_d & som & (estado_d == NOTA) & conta & nota_valida(nota_d);
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= OCIOSO;
            t_q      <= '0;
            div_q    <= 17'd0;
            tom_q    <= 1'b0;
            nota_q   <= 4'd0;
            muda_q   <= 1'b0;
            buzzer_q <= 1'b0;
        end else begin
            estado_q <= estado_d;
            t_q      <= t_d;
            div_q    <= div_d;
            tom_q    <= tom_d;
            nota_q   <= nota_d;
            muda_q   <= muda_d;
            buzzer_q <= buzzer_d;
        end
    end

    assign buzzer     = buzzer_q;
    assign muda_nota  = muda_q;
    assign ocupado    = (estado_q != OCIOSO);
    assign nota_atual = nota_q;
    assign db_estado  = estado_q;

endmodule

// File: tb/tb_tocador_nota.sv
// Scoreboard bench for tocador_nota: expected muda_nota pulse cycles and buzzer edges
// are queued when stimulus is applied and compared as the DUT produces them.
module tb_tocador_nota;

    logic       clock = 1'b0;
    logic       reset;
    logic       zera;
    logic       conta;
    logic       som;
    logic [3:0] nota;
    logic       buzzer;
    logic       muda_nota;
    logic       ocupado;
    logic [3:0] nota_atual;
    logic [1:0] db_estado;

    tocador_nota #(
        .T_NOTA (200),
        .T_PAUSA(40),
        .T_W    (25),
        .ESCALA (10)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .zera      (zera),
        .conta     (conta),
        .som       (som),
        .nota      (nota),
        .buzzer    (buzzer),
        .muda_nota (muda_nota),
        .ocupado   (ocupado),
        .nota_atual(nota_atual),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    int unsigned muda_exp_q[$];
    int unsigned buz_t_q[$];
    logic        buz_v_q[$];
    logic        buz_prev = 1'b0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_until(input int unsigned n);
        while (cyc < n) @(negedge clock);
    endtask

    task automatic push_buz(input int unsigned t, input logic v);
        buz_t_q.push_back(t);
        buz_v_q.push_back(v);
    endtask

    // Monitor: every muda_nota pulse and buzzer edge must match the scoreboard.
    always @(negedge clock) begin
        if (muda_nota) begin
            if (muda_exp_q.size() == 0) check("muda_extra", cyc, 0);
            else check("muda_cyc", cyc, muda_exp_q.pop_front());
        end
        if (buzzer !== buz_prev) begin
            if (buz_t_q.size() == 0) begin
                check("buz_extra", cyc, 0);
            end else begin
                check("buz_cyc", cyc, buz_t_q.pop_front());
                check("buz_val", buzzer, buz_v_q.pop_front());
            end
        end
        buz_prev = buzzer;
    end

    int unsigned c0, c1, c2, c3, c4;

    initial begin
        reset = 1'b0; zera = 1'b0; conta = 1'b0; som = 1'b0; nota = 4'd0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rst_estado", db_estado, 0);
        check("rst_buzzer", buzzer, 0);
        check("rst_muda", muda_nota, 0);
        check("rst_ocupado", ocupado, 0);
        check("rst_nota", nota_atual, 0);

        // nota 6 with sound: half-period 56818>>10 = 55
        c0 = cyc; nota = 4'd6; som = 1'b1; conta = 1'b1;
        muda_exp_q.push_back(c0 + 201);
        muda_exp_q.push_back(c0 + 241);
        muda_exp_q.push_back(c0 + 441);
        push_buz(c0 + 56, 1'b1);  push_buz(c0 + 111, 1'b0);
        push_buz(c0 + 166, 1'b1); push_buz(c0 + 201, 1'b0);
        push_buz(c0 + 296, 1'b1); push_buz(c0 + 351, 1'b0);
        push_buz(c0 + 406, 1'b1); push_buz(c0 + 441, 1'b0);
        wait_until(c0 + 1);
        check("nota_estado", db_estado, 1);
        check("nota_ocupado", ocupado, 1);
        check("nota_latch", nota_atual, 6);
        wait_until(c0 + 220);
        check("pausa_estado", db_estado, 2);
        check("pausa_ocupado", ocupado, 1);
        wait_until(c0 + 450);
        check("nota_latch2", nota_atual, 6);
        zera = 1'b1;
        wait_until(c0 + 451);
        check("zera_estado", db_estado, 0);
        check("zera_nota", nota_atual, 0);
        check("zera_ocupado", ocupado, 0);
        zera = 1'b0; conta = 1'b0;
        @(negedge clock);

        // som=0: identical timing, silent buzzer
        c1 = cyc; som = 1'b0; conta = 1'b1;
        muda_exp_q.push_back(c1 + 201);
        muda_exp_q.push_back(c1 + 241);
        wait_until(c1 + 250);
        zera = 1'b1;
        wait_until(c1 + 251);
        zera = 1'b0; conta = 1'b0;
        @(negedge clock);

        // conta gap of 30 cycles at t=100 of NOTA
        c2 = cyc; som = 1'b1; conta = 1'b1;
        muda_exp_q.push_back(c2 + 231);
        push_buz(c2 + 56, 1'b1);  push_buz(c2 + 102, 1'b0);
        push_buz(c2 + 132, 1'b1); push_buz(c2 + 141, 1'b0);
        push_buz(c2 + 196, 1'b1); push_buz(c2 + 231, 1'b0);
        wait_until(c2 + 101);
        conta = 1'b0;
        wait_until(c2 + 115);
        check("gap_buzzer", buzzer, 0);
        check("gap_estado", db_estado, 1);
        wait_until(c2 + 131);
        conta = 1'b1;
        wait_until(c2 + 240);
        zera = 1'b1;
        wait_until(c2 + 241);
        zera = 1'b0; conta = 1'b0;
        @(negedge clock);

        // silent code 0, then code 3 (75758>>10 = 73) applied mid-NOTA
        c3 = cyc; nota = 4'd0; som = 1'b1; conta = 1'b1;
        muda_exp_q.push_back(c3 + 201);
        muda_exp_q.push_back(c3 + 241);
        muda_exp_q.push_back(c3 + 441);
        push_buz(c3 + 314, 1'b1); push_buz(c3 + 387, 1'b0);
        wait_until(c3 + 100);
        nota = 4'd3;
        wait_until(c3 + 150);
        check("midnota_ign", nota_atual, 0);
        wait_until(c3 + 250);
        check("relatch", nota_atual, 3);
        // zera on the PAUSA phase-end cycle suppresses the pulse
        wait_until(c3 + 480);
        zera = 1'b1;
        wait_until(c3 + 481);
        check("zera_fim_estado", db_estado, 0);
        check("zera_fim_muda", muda_nota, 0);
        zera = 1'b0; conta = 1'b0;
        @(negedge clock);

        // async reset mid-PAUSA; code 5 half-period 63776>>10 = 62
        c4 = cyc; nota = 4'd5; som = 1'b1; conta = 1'b1;
        muda_exp_q.push_back(c4 + 201);
        push_buz(c4 + 63, 1'b1);  push_buz(c4 + 125, 1'b0);
        push_buz(c4 + 187, 1'b1); push_buz(c4 + 201, 1'b0);
        wait_until(c4 + 221);
        check("pre_rst_estado", db_estado, 2);
        reset = 1'b0;
        #1;
        check("arst_estado", db_estado, 0);
        check("arst_ocupado", ocupado, 0);
        check("arst_nota", nota_atual, 0);
        check("arst_muda", muda_nota, 0);
        check("arst_buzzer", buzzer, 0);
        conta = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (50) @(negedge clock);
        check("post_rst_estado", db_estado, 0);

        check("muda_pending", muda_exp_q.size(), 0);
        check("buz_pending", buz_t_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
